// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush and a
// downstream bubble counter. SKID=1 gives a registered up_ready; SKID=0 a single register.
module pipe_skid_reg #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   NOP_VAL = '0,
  parameter bit              SKID    = 1'b1,
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [DW-1:0]    up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [DW-1:0]    dn_data,
  output logic [1:0]       occ,
  input  logic             bubble_clr,
  output logic [CNT_W-1:0] bubble_cnt
);

  // State encoding equals the number of held entries, so occ is the state itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t        state, state_nxt;
  logic [DW-1:0] main_q, skid_q;
  logic          accept, consume;
  logic          main_ld, main_from_skid, skid_ld;

  assign dn_valid = (state != S_EMPTY);
  assign dn_data  = dn_valid ? main_q : NOP_VAL;
  assign occ      = state;

  generate
    if (SKID) begin : g_skid_ready
      // Registered ready: depends only on held state and flush, never on dn_ready.
      assign up_ready = (state != S_FULL) & ~flush;
    end else begin : g_reg_ready
      assign up_ready = (~dn_valid | dn_ready) & ~flush;
    end
  endgenerate

  assign accept  = up_valid & up_ready;
  assign consume = dn_valid & dn_ready;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          state_nxt = S_ONE;
          main_ld   = 1'b1;
        end
      end
      S_ONE: begin
        // With SKID=0 accept implies consume, so the FULL branch is unreachable there.
        if (accept && consume) begin
          main_ld = 1'b1;
        end else if (accept) begin
          state_nxt = S_FULL;
          skid_ld   = 1'b1;
        end else if (consume) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (consume) begin
          state_nxt      = S_ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      state_nxt      = S_EMPTY;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // NOTE: payload registers are reset too, so a post-reset dn_data never exposes stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= NOP_VAL;
      skid_q <= NOP_VAL;
    end else begin
      if (main_ld) main_q <= main_from_skid ? skid_q : up_data;
      if (skid_ld) skid_q <= up_data;
    end
  end

  // Counts cycles with no head entry; saturates, clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || bubble_clr) begin
      bubble_cnt <= '0;
    end else if (!dn_valid && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench: a SKID=1 and a SKID=0 instance share stimulus and are
// each compared every cycle against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int          DW    = 8;
  localparam int          CNT_W = 4;
  localparam logic [7:0]  NOP   = 8'hEE;
  localparam int          CMAX  = 15;

  logic clk = 1'b0;
  logic rst, flush, up_valid, dn_ready, bubble_clr;
  logic [DW-1:0] up_data;

  logic             up_ready_s, dn_valid_s, up_ready_r, dn_valid_r;
  logic [DW-1:0]    dn_data_s, dn_data_r;
  logic [1:0]       occ_s, occ_r;
  logic [CNT_W-1:0] bcnt_s, bcnt_r;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_r[$];
  int cnt_s = 0;
  int cnt_r = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DW(DW), .NOP_VAL(NOP), .SKID(1'b1), .CNT_W(CNT_W)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(up_ready_s),
    .up_data(up_data), .dn_valid(dn_valid_s), .dn_ready(dn_ready), .dn_data(dn_data_s),
    .occ(occ_s), .bubble_clr(bubble_clr), .bubble_cnt(bcnt_s)
  );

  pipe_skid_reg #(.DW(DW), .NOP_VAL(NOP), .SKID(1'b0), .CNT_W(CNT_W)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(up_ready_r),
    .up_data(up_data), .dn_valid(dn_valid_r), .dn_ready(dn_ready), .dn_data(dn_data_r),
    .occ(occ_r), .bubble_clr(bubble_clr), .bubble_cnt(bcnt_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, advance the model, cross the edge.
  task automatic tick();
    logic rdy_s, rdy_r, acc_s, acc_r, con_s, con_r;
    @(negedge clk);
    rdy_s = (q_s.size() != 2) && !flush;
    rdy_r = ((q_r.size() == 0) || dn_ready) && !flush;
    check("skid_up_ready", 32'(up_ready_s), 32'(rdy_s));
    check("skid_dn_valid", 32'(dn_valid_s), 32'(q_s.size() != 0));
    check("skid_dn_data",  32'(dn_data_s),  32'((q_s.size() != 0) ? q_s[0] : NOP));
    check("skid_occ",      32'(occ_s),      32'(q_s.size()));
    check("skid_bubble",   32'(bcnt_s),     32'(cnt_s));
    check("reg_up_ready",  32'(up_ready_r), 32'(rdy_r));
    check("reg_dn_valid",  32'(dn_valid_r), 32'(q_r.size() != 0));
    check("reg_dn_data",   32'(dn_data_r),  32'((q_r.size() != 0) ? q_r[0] : NOP));
    check("reg_occ",       32'(occ_r),      32'(q_r.size()));
    check("reg_bubble",    32'(bcnt_r),     32'(cnt_r));

    acc_s = up_valid && rdy_s;
    acc_r = up_valid && rdy_r;
    con_s = (q_s.size() != 0) && dn_ready;
    con_r = (q_r.size() != 0) && dn_ready;
    if (rst) begin
      q_s.delete(); q_r.delete();
      cnt_s = 0; cnt_r = 0;
    end else begin
      if (bubble_clr) cnt_s = 0;
      else if (q_s.size() == 0 && cnt_s < CMAX) cnt_s++;
      if (bubble_clr) cnt_r = 0;
      else if (q_r.size() == 0 && cnt_r < CMAX) cnt_r++;
      if (flush) begin
        q_s.delete(); q_r.delete();
      end else begin
        if (con_s) void'(q_s.pop_front());
        if (acc_s) q_s.push_back(up_data);
        if (con_r) void'(q_r.pop_front());
        if (acc_r) q_r.push_back(up_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0;
    dn_ready = 1'b0; bubble_clr = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with an entry offered: it must be discarded.
    up_valid = 1'b1; up_data = 8'h55;
    tick(); tick();
    rst = 1'b0; up_valid = 1'b0;

    // Idle: bubble counter saturates at 15, then clears and resumes.
    repeat (20) tick();
    bubble_clr = 1'b1; tick();
    bubble_clr = 1'b0;
    repeat (3) tick();

    // Stall with three consecutive offers, then drain in order.
    dn_ready = 1'b0; up_valid = 1'b1;
    up_data = 8'hA1; tick();
    up_data = 8'hA2; tick();
    up_data = 8'hA3; tick();
    dn_ready = 1'b1;
    tick(); tick();
    up_valid = 1'b0;
    repeat (3) tick();

    // Streaming: 100 back-to-back entries with downstream always ready.
    dn_ready = 1'b1; up_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      up_data = 8'(i + 8'h10);
      tick();
    end
    up_valid = 1'b0;
    repeat (2) tick();

    // Flush while full with a concurrent offer.
    dn_ready = 1'b0; up_valid = 1'b1;
    up_data = 8'hB1; tick();
    up_data = 8'hB2; tick();
    flush = 1'b1; up_data = 8'hB3; tick();
    flush = 1'b0; up_valid = 1'b0;
    repeat (2) tick();

    // Constant offer with toggling downstream ready.
    up_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dn_ready = (i % 2 == 0);
      up_data  = 8'(8'hC0 + i);
      tick();
    end
    up_valid = 1'b0; dn_ready = 1'b1;
    repeat (2) tick();

    // Reset while full, concurrent with flush; then first accept from empty.
    dn_ready = 1'b0; up_valid = 1'b1;
    up_data = 8'hD1; tick();
    up_data = 8'hD2; tick();
    rst = 1'b1; flush = 1'b1; up_data = 8'hD3; tick();
    rst = 1'b0; flush = 1'b0; up_data = 8'hD4; tick();
    up_valid = 1'b0; dn_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic with occasional flush, clear and reset.
    for (int i = 0; i < 400; i++) begin
      up_valid   = ($urandom_range(0, 3) != 0);
      dn_ready   = ($urandom_range(0, 2) != 0);
      up_data    = 8'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      bubble_clr = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; bubble_clr = 1'b0; up_valid = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
